// File: rtl/ext_target_unit.sv
// ext_target_unit
//   Two-stage valid/ready pipeline that produces the immediate-extension operand
//   and the next-PC candidate for one decoded instruction.
//   S1 decodes the mode, registers the extended operand, pc+4, a target class
//   and the J/JR target candidate. S2 resolves the final target (BR adder lives
//   here) plus the misaligned/illegal flags. Outputs come straight from S2.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of both stages
//   in_valid/in_ready   request handshake (mode, pc, imm, jidx, rs_val)
//   out_valid/out_ready result handshake (ext_out, target, misaligned, illegal)
module ext_target_unit #(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int JIDX_W = 26,
    parameter int SHIFT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        mode,
    input  logic [DATA_W-1:0] pc,
    input  logic [IMM_W-1:0]  imm,
    input  logic [JIDX_W-1:0] jidx,
    input  logic [DATA_W-1:0] rs_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] ext_out,
    output logic [DATA_W-1:0] target,
    output logic              misaligned,
    output logic              illegal
);

    generate
        if (DATA_W <= IMM_W + SHIFT || DATA_W < JIDX_W + SHIFT) begin : g_bad_params
            $error("ext_target_unit: DATA_W too small for IMM_W/JIDX_W/SHIFT");
        end
    endgenerate

    localparam logic [2:0] M_ZEXT = 3'd0;
    localparam logic [2:0] M_SEXT = 3'd1;
    localparam logic [2:0] M_BR   = 3'd2;
    localparam logic [2:0] M_LUI  = 3'd3;
    localparam logic [2:0] M_J    = 3'd4;
    localparam logic [2:0] M_JR   = 3'd5;

    // Low bits of p4 replaced by the shifted jump index (region-relative jump).
    localparam logic [DATA_W-1:0] J_LOW_MASK = (DATA_W'(1) << (JIDX_W + SHIFT)) - DATA_W'(1);
    localparam logic [DATA_W-1:0] ALIGN_MASK = (DATA_W'(1) << SHIFT) - DATA_W'(1);

    // How S2 picks the final target.
    typedef enum logic [1:0] {CLS_P4, CLS_BR, CLS_FIX, CLS_ILL} cls_e;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_ext_q,   s1_ext_d;
    logic [DATA_W-1:0] s1_p4_q,    s1_p4_d;
    logic [DATA_W-1:0] s1_tgt_q,   s1_tgt_d;
    cls_e              s1_cls_q,   s1_cls_d;

    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] s2_ext_q,   s2_ext_d;
    logic [DATA_W-1:0] s2_tgt_q,   s2_tgt_d;
    logic              s2_mis_q,   s2_mis_d;
    logic              s2_ill_q,   s2_ill_d;

    logic              s2_adv;
    logic [DATA_W-1:0] p4;
    logic [DATA_W-1:0] dec_ext, dec_tgt, fin_tgt;
    cls_e              dec_cls;

    assign s2_adv   = !s2_valid_q || out_ready;
    // S1 moves exactly when S2 does; S1 can still fill while empty under a stall.
    assign in_ready = (!s1_valid_q || s2_adv) && !flush;
    assign p4       = pc + DATA_W'(4);

    always_comb begin
        dec_ext = '0;
        dec_tgt = '0;
        dec_cls = CLS_P4;
        case (mode)
            M_ZEXT: dec_ext = DATA_W'(imm);
            M_SEXT: dec_ext = DATA_W'($signed(imm));
            M_BR: begin
                dec_ext = DATA_W'($signed(imm)) << SHIFT;
                dec_cls = CLS_BR;
            end
            M_LUI:  dec_ext = DATA_W'(imm) << (DATA_W - IMM_W);
            M_J: begin
                dec_ext = DATA_W'(jidx) << SHIFT;
                dec_tgt = (p4 & ~J_LOW_MASK) | (DATA_W'(jidx) << SHIFT);
                dec_cls = CLS_FIX;
            end
            M_JR: begin
                dec_ext = rs_val;
                dec_tgt = rs_val;
                dec_cls = CLS_FIX;
            end
            default: dec_cls = CLS_ILL;
        endcase
    end

    always_comb begin
        case (s1_cls_q)
            CLS_BR:  fin_tgt = s1_p4_q + s1_ext_q;
            CLS_FIX: fin_tgt = s1_tgt_q;
            default: fin_tgt = s1_p4_q;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_ext_d   = s1_ext_q;
        s1_p4_d    = s1_p4_q;
        s1_tgt_d   = s1_tgt_q;
        s1_cls_d   = s1_cls_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_ext_d = dec_ext;
                s1_p4_d  = p4;
                s1_tgt_d = dec_tgt;
                s1_cls_d = dec_cls;
            end
        end

        s2_valid_d = s2_valid_q;
        s2_ext_d   = s2_ext_q;
        s2_tgt_d   = s2_tgt_q;
        s2_mis_d   = s2_mis_q;
        s2_ill_d   = s2_ill_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_ext_d = s1_ext_q;
                s2_tgt_d = fin_tgt;
                s2_mis_d = (fin_tgt & ALIGN_MASK) != '0;
                s2_ill_d = (s1_cls_q == CLS_ILL);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_ext_q   <= '0;
            s1_p4_q    <= '0;
            s1_tgt_q   <= '0;
            s1_cls_q   <= CLS_P4;
            s2_valid_q <= 1'b0;
            s2_ext_q   <= '0;
            s2_tgt_q   <= '0;
            s2_mis_q   <= 1'b0;
            s2_ill_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_ext_q   <= s1_ext_d;
            s1_p4_q    <= s1_p4_d;
            s1_tgt_q   <= s1_tgt_d;
            s1_cls_q   <= s1_cls_d;
            s2_valid_q <= s2_valid_d;
            s2_ext_q   <= s2_ext_d;
            s2_tgt_q   <= s2_tgt_d;
            s2_mis_q   <= s2_mis_d;
            s2_ill_q   <= s2_ill_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign ext_out    = s2_ext_q;
    assign target     = s2_tgt_q;
    assign misaligned = s2_mis_q;
    assign illegal    = s2_ill_q;

endmodule

// File: tb/tb_ext_target_unit.sv
module tb_ext_target_unit;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  mode;
    logic [31:0] pc, rs_val, ext_out, target;
    logic [15:0] imm;
    logic [25:0] jidx;
    logic        misaligned, illegal;

    logic        d64_flush, d64_in_valid, d64_in_ready, d64_out_valid, d64_out_ready;
    logic [2:0]  d64_mode;
    logic [63:0] d64_pc, d64_rs_val, d64_ext_out, d64_target;
    logic [15:0] d64_imm;
    logic [25:0] d64_jidx;
    logic        d64_misaligned, d64_illegal;

    always #5 clk = ~clk;

    ext_target_unit u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .mode(mode), .pc(pc), .imm(imm),
        .jidx(jidx), .rs_val(rs_val), .out_valid(out_valid), .out_ready(out_ready),
        .ext_out(ext_out), .target(target), .misaligned(misaligned), .illegal(illegal)
    );

    ext_target_unit #(.DATA_W(64), .IMM_W(16), .JIDX_W(26), .SHIFT(2)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(d64_flush),
        .in_valid(d64_in_valid), .in_ready(d64_in_ready), .mode(d64_mode), .pc(d64_pc),
        .imm(d64_imm), .jidx(d64_jidx), .rs_val(d64_rs_val), .out_valid(d64_out_valid),
        .out_ready(d64_out_ready), .ext_out(d64_ext_out), .target(d64_target),
        .misaligned(d64_misaligned), .illegal(d64_illegal)
    );

    typedef struct {
        logic [31:0] ext;
        logic [31:0] tgt;
        logic        mis;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          n_out = 0;
    logic        ov_s, rdy_s, mis_s, ill_s;
    logic [31:0] ext_s, tgt_s;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Reference: plain integer arithmetic on the mode table, everything mod 2^32.
    function automatic exp_t model(input logic [2:0] m, input logic [31:0] pc_i,
                                   input logic [15:0] imm_i, input logic [25:0] j_i,
                                   input logic [31:0] rs_i);
        exp_t   e;
        longint m32, p4, simm, t;
        m32  = 64'h1_0000_0000;
        p4   = (longint'(pc_i) + 4) % m32;
        simm = (imm_i >= 16'h8000) ? longint'(imm_i) - 65536 : longint'(imm_i);
        e.ill = 1'b0;
        t     = p4;
        case (m)
            3'd0: e.ext = 32'(longint'(imm_i));
            3'd1: e.ext = 32'((simm + m32) % m32);
            3'd2: begin
                e.ext = 32'((simm * 4 + m32) % m32);
                t     = (p4 + simm * 4 + m32) % m32;
            end
            3'd3: e.ext = 32'(longint'(imm_i) * 65536);
            3'd4: begin
                e.ext = 32'(longint'(j_i) * 4);
                t     = (p4 / (64'd1 << 28)) * (64'd1 << 28) + longint'(j_i) * 4;
            end
            3'd5: begin
                e.ext = rs_i;
                t     = longint'(rs_i);
            end
            default: begin
                e.ext = 32'd0;
                e.ill = 1'b1;
            end
        endcase
        e.tgt = 32'(t);
        e.mis = (t % 4) != 0;
        return e;
    endfunction

    // One clock cycle: sample at negedge, score handshakes, return at posedge+1.
    task automatic step();
        exp_t e;
        @(negedge clk);
        ov_s = out_valid; rdy_s = in_ready; ext_s = ext_out; tgt_s = target;
        mis_s = misaligned; ill_s = illegal;
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = sb[0];
                chk("ext", 64'(ext_out), 64'(e.ext));
                chk("tgt", 64'(target), 64'(e.tgt));
                chk("mis", 64'(misaligned), 64'(e.mis));
                chk("ill", 64'(illegal), 64'(e.ill));
                if (out_ready) begin
                    sb.delete(0);
                    n_out++;
                end
            end
        end
        if (flush) begin
            chk("flush_blocks_in", 64'(in_ready), 64'd0);
            sb.delete();
        end else if (in_valid && in_ready) begin
            sb.push_back(model(mode, pc, imm, jidx, rs_val));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        repeat (4) step();
    endtask

    task automatic set_req(input logic [2:0] m, input logic [31:0] p, input logic [15:0] im,
                           input logic [25:0] j, input logic [31:0] rs);
        mode = m; pc = p; imm = im; jidx = j; rs_val = rs;
    endtask

    task automatic req_chk(input string tag, input logic [2:0] m, input logic [31:0] p,
                           input logic [15:0] im, input logic [25:0] j, input logic [31:0] rs,
                           input logic [31:0] w_ext, input logic [31:0] w_tgt,
                           input logic w_mis, input logic w_ill);
        drain();
        set_req(m, p, im, j, rs);
        in_valid = 1'b1;
        step();
        chk({tag, "_acc"}, 64'(rdy_s), 64'd1);
        in_valid = 1'b0;
        step();
        chk({tag, "_lat1"}, 64'(ov_s), 64'd0);
        step();
        chk({tag, "_lat2"}, 64'(ov_s), 64'd1);
        chk({tag, "_ext"}, 64'(ext_s), 64'(w_ext));
        chk({tag, "_tgt"}, 64'(tgt_s), 64'(w_tgt));
        chk({tag, "_mis"}, 64'(mis_s), 64'(w_mis));
        chk({tag, "_ill"}, 64'(ill_s), 64'(w_ill));
    endtask

    initial begin
        int n0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_req(3'd0, 32'd0, 16'd0, 26'd0, 32'd0);
        d64_flush = 1'b0; d64_in_valid = 1'b0; d64_out_ready = 1'b1; d64_mode = 3'd2;
        d64_pc = 64'd0; d64_imm = 16'hFFFE; d64_jidx = 26'd0; d64_rs_val = 64'd0;

        #12;
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_ext", 64'(ext_out), 64'd0);
        chk("rst_tgt", 64'(target), 64'd0);
        chk("rst_flags", 64'({misaligned, illegal}), 64'd0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_rdy", 64'(in_ready), 64'd1);

        // 64-bit variant: BR imm=0xFFFE, pc=0
        d64_in_valid = 1'b1;
        @(negedge clk);
        chk("w64_acc", 64'(d64_in_ready), 64'd1);
        @(posedge clk); #1;
        d64_in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("w64_ov", 64'(d64_out_valid), 64'd1);
        chk("w64_ext", d64_ext_out, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("w64_tgt", d64_target, 64'hFFFF_FFFF_FFFF_FFFC);
        @(posedge clk); #1;

        req_chk("br_neg", 3'd2, 32'h0040_0000, 16'hFFFF, 26'd0, 32'd0, 32'hFFFF_FFFC, 32'h0040_0000, 1'b0, 1'b0);
        req_chk("br_pos", 3'd2, 32'h0040_0000, 16'h0004, 26'd0, 32'd0, 32'h0000_0010, 32'h0040_0014, 1'b0, 1'b0);
        req_chk("lui", 3'd3, 32'h0000_1000, 16'h1234, 26'd0, 32'd0, 32'h1234_0000, 32'h0000_1004, 1'b0, 1'b0);
        req_chk("sext", 3'd1, 32'h0000_1000, 16'h8000, 26'd0, 32'd0, 32'hFFFF_8000, 32'h0000_1004, 1'b0, 1'b0);
        req_chk("zext", 3'd0, 32'h0000_1000, 16'h8000, 26'd0, 32'd0, 32'h0000_8000, 32'h0000_1004, 1'b0, 1'b0);
        req_chk("j", 3'd4, 32'h9000_0000, 16'd0, 26'h010_0000, 32'd0, 32'h0040_0000, 32'h9040_0000, 1'b0, 1'b0);
        req_chk("jr", 3'd5, 32'h0000_1000, 16'd0, 26'd0, 32'h0040_0002, 32'h0040_0002, 32'h0040_0002, 1'b1, 1'b0);
        req_chk("rsvd6", 3'd6, 32'h0000_1000, 16'h5555, 26'd0, 32'd0, 32'h0000_0000, 32'h0000_1004, 1'b0, 1'b1);
        req_chk("wrap_z", 3'd0, 32'hFFFF_FFFC, 16'h0001, 26'd0, 32'd0, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
        req_chk("wrap_br", 3'd2, 32'hFFFF_FFF8, 16'h0001, 26'd0, 32'd0, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b0);

        // Back-pressure: A, B, C back-to-back, sink stalls 4 cycles once A is in S2
        drain();
        n0 = n_out;
        in_valid = 1'b1;
        set_req(3'd1, 32'h100, 16'hA001, 26'd0, 32'd0); step();
        set_req(3'd2, 32'h200, 16'h0B02, 26'd0, 32'd0); step();
        set_req(3'd5, 32'h300, 16'd0, 26'd0, 32'h0000_0C03);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_stall_rdy", 64'(rdy_s), 64'd0);
            chk("bp_hold_ov", 64'(ov_s), 64'd1);
        end
        chk("bp_two_acc", 64'(sb.size()), 64'd2);
        out_ready = 1'b1;
        step();
        chk("bp_release_acc", 64'(rdy_s), 64'd1);
        in_valid = 1'b0;
        repeat (4) step();
        chk("bp_out_count", 64'(n_out - n0), 64'd3);
        chk("bp_empty", 64'(sb.size()), 64'd0);

        // Flush with both stages full
        drain();
        out_ready = 1'b0; in_valid = 1'b1;
        set_req(3'd0, 32'h400, 16'h1111, 26'd0, 32'd0); step();
        set_req(3'd1, 32'h500, 16'h2222, 26'd0, 32'd0); step();
        in_valid = 1'b0; step();
        flush = 1'b1; in_valid = 1'b1;
        set_req(3'd3, 32'h600, 16'h3333, 26'd0, 32'd0);
        step();
        flush = 1'b0; out_ready = 1'b1;
        step();
        chk("fl_ov_cleared", 64'(ov_s), 64'd0);
        chk("fl_next_acc", 64'(rdy_s), 64'd1);
        in_valid = 1'b0;
        step();
        chk("fl_lat1", 64'(ov_s), 64'd0);
        step();
        chk("fl_lat2", 64'(ov_s), 64'd1);

        // Asynchronous reset with entries in flight
        drain();
        out_ready = 1'b0; in_valid = 1'b1;
        set_req(3'd1, 32'h700, 16'h8001, 26'd0, 32'd0); step();
        set_req(3'd5, 32'h800, 16'd0, 26'd0, 32'h0000_0123); step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", 64'(out_valid), 64'd0);
        chk("arst_ext", 64'(ext_out), 64'd0);
        chk("arst_tgt", 64'(target), 64'd0);
        chk("arst_flags", 64'({misaligned, illegal}), 64'd0);
        sb.delete();
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        step();
        chk("arst_rdy", 64'(rdy_s), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("arst_no_ghost", 64'(ov_s), 64'd0);
        end

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 31) == 0);
            mode      = 3'($urandom_range(0, 7));
            pc        = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            imm       = 16'($urandom);
            jidx      = 26'($urandom);
            rs_val    = $urandom;
            step();
        end
        drain();
        chk("final_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
